// File: rtl/rle_pkg.sv
// ----------------------------------------------------------------------------
// rle_pkg
// Shared definitions for the RLE encoder front end: the fixed data width
// used by the XOR comparator, the default run-counter width and the encoder
// FSM state type.
// ----------------------------------------------------------------------------
package rle_pkg;

    localparam int RLE_DATA_W = 32;
    localparam int RLE_CNT_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rle_state_t;

endpackage

// File: rtl/xor_gate.sv
// ----------------------------------------------------------------------------
// xor_gate
// Bitwise 32-bit XOR datapath used by the run-length encoder to compare the
// held word against the incoming word.
//
// Ports:
//   a_i  in  32  first operand
//   b_i  in  32  second operand
//   y_o  out 32  a_i ^ b_i
// ----------------------------------------------------------------------------
module xor_gate
    import rle_pkg::*;
(
    input  logic [RLE_DATA_W-1:0] a_i,
    input  logic [RLE_DATA_W-1:0] b_i,
    output logic [RLE_DATA_W-1:0] y_o
);

    assign y_o = a_i ^ b_i;

endmodule

// File: rtl/rle_xor_encoder.sv
// ----------------------------------------------------------------------------
// rle_xor_encoder
// Streaming run-length encoder front end. Accepted 32-bit words are compared
// with the held word through xor_gate; equal words extend the current run,
// a different word (or a saturated run, or a flush) emits a (word, length)
// token into a single registered output slot.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      input word valid
//   in_ready   out  1      input word accepted (combinational)
//   in_data    in   32     input word
//   flush      in   1      close and emit the current run (level)
//   out_valid  out  1      token valid (registered)
//   out_ready  in   1      downstream accepts the token
//   out_data   out  32     run word
//   out_count  out  CNT_W  run length, 1..2^CNT_W-1
// ----------------------------------------------------------------------------
module rle_xor_encoder
    import rle_pkg::*;
#(
    parameter int CNT_W = RLE_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [RLE_DATA_W-1:0] in_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RLE_DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]      out_count
);

    localparam logic [CNT_W-1:0] MAX_COUNT = '1;
    localparam logic [CNT_W-1:0] ONE_COUNT = CNT_W'(1);

    rle_state_t            state_q;
    logic [RLE_DATA_W-1:0] hold_q;
    logic [CNT_W-1:0]      count_q;
    logic                  outValid_q;
    logic [RLE_DATA_W-1:0] outData_q;
    logic [CNT_W-1:0]      outCount_q;

    logic [RLE_DATA_W-1:0] diff;
    logic                  match;
    logic                  slotFree;
    logic                  accept;

    xor_gate U_xor_gate (
        .a_i (hold_q),
        .b_i (in_data),
        .y_o (diff)
    );

    assign match    = ~|diff;
    // The slot can take a new token if it is empty or being drained this cycle.
    assign slotFree = !outValid_q || out_ready;
    // Flush blocks input so a flush and an accepted word never share a cycle.
    assign in_ready = !flush && slotFree;
    assign accept   = in_valid && in_ready;

    // Encoder FSM, run counter and output slot. A drain clears out_valid
    // first; any load later in the same cycle overrides that clear so the
    // new token replaces the old one without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            count_q    <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outCount_q <= '0;
        end else begin
            if (outValid_q && out_ready) begin
                outValid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        hold_q  <= in_data;
                        count_q <= ONE_COUNT;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (match && (count_q < MAX_COUNT)) begin
                            count_q <= count_q + ONE_COUNT;
                        end else begin
                            // Break on a new word or a saturated run.
                            outValid_q <= 1'b1;
                            outData_q  <= hold_q;
                            outCount_q <= count_q;
                            hold_q     <= in_data;
                            count_q    <= ONE_COUNT;
                        end
                    end else if (flush && slotFree) begin
                        outValid_q <= 1'b1;
                        outData_q  <= hold_q;
                        outCount_q <= count_q;
                        count_q    <= '0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_count = outCount_q;

endmodule

// File: tb/tb_rle_xor_encoder.sv
// ----------------------------------------------------------------------------
// tb_rle_xor_encoder
// Directed self-checking bench for rle_xor_encoder. Inputs change and outputs
// are sampled 1 time unit after each rising clock edge.
// ----------------------------------------------------------------------------
module tb_rle_xor_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_count;

    int errors;
    int checks;

    rle_xor_encoder #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive the input side for the next clock edge.
    task automatic applyStimulus(input logic v, input logic [31:0] d,
                                 input logic f, input logic r);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = r;
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Check the whole output slot in one call.
    task automatic checkToken(input string tag, input logic v,
                              input logic [31:0] d, input logic [7:0] c);
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'(v));
        if (v) begin
            checkOutput({tag, "_data"}, 64'(out_data), 64'(d));
            checkOutput({tag, "_count"}, 64'(out_count), 64'(c));
        end
    endtask

    initial begin
        int          tokens;
        logic [31:0] satData;
        logic [7:0]  satCount;
        int          satIndex;

        errors = 0;
        checks = 0;

        // ---------------- reset ----------------
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_count", 64'(out_count), 64'd0);
        checkOutput("rst_out_data", 64'(out_data), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("idle_no_token", 64'(out_valid), 64'd0);
        end

        // ---------------- basic runs ----------------
        applyStimulus(1'b1, 32'h0000_1111, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        checkOutput("basic_no_early_token", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, 32'h5555_5555, 1'b0, 1'b1);
        tick();
        checkToken("basic_tok1", 1'b1, 32'h0000_1111, 8'd3);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        checkToken("basic_tok2", 1'b1, 32'h5555_5555, 8'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput("basic_drained", 64'(out_valid), 64'd0);

        // ---------------- saturation ----------------
        tokens   = 0;
        satData  = '0;
        satCount = '0;
        satIndex = 0;
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (out_valid) begin
                tokens++;
                satData  = out_data;
                satCount = out_count;
                satIndex = i;
            end
        end
        checkOutput("sat_token_count", 64'(tokens), 64'd1);
        checkOutput("sat_token_index", 64'(satIndex), 64'd256);
        checkOutput("sat_token_data", 64'(satData), 64'hFFFF_FFFF);
        checkOutput("sat_token_len", 64'(satCount), 64'd255);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        checkToken("sat_flush", 1'b1, 32'hFFFF_FFFF, 8'd45);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        tick();

        // ---------------- backpressure ----------------
        applyStimulus(1'b1, 32'h0000_0001, 1'b0, 1'b0);
        #1;
        checkOutput("bp_ready_A", 64'(in_ready), 64'd1);
        tick();
        applyStimulus(1'b1, 32'h0000_0002, 1'b0, 1'b0);
        #1;
        checkOutput("bp_ready_B", 64'(in_ready), 64'd1);
        tick();
        checkToken("bp_tokA", 1'b1, 32'h0000_0001, 8'd1);
        applyStimulus(1'b1, 32'h0000_0003, 1'b0, 1'b0);
        #1;
        checkOutput("bp_ready_C_stall", 64'(in_ready), 64'd0);
        tick();
        checkToken("bp_tokA_hold1", 1'b1, 32'h0000_0001, 8'd1);
        tick();
        checkToken("bp_tokA_hold2", 1'b1, 32'h0000_0001, 8'd1);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_ready_C_release", 64'(in_ready), 64'd1);
        tick();
        checkToken("bp_tokB", 1'b1, 32'h0000_0002, 8'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        checkToken("bp_tokC", 1'b1, 32'h0000_0003, 8'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput("bp_drained", 64'(out_valid), 64'd0);

        // ---------------- flush corners ----------------
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        #1;
        checkOutput("flush_idle_ready", 64'(in_ready), 64'd0);
        tick();
        tick();
        checkOutput("flush_idle_no_token", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, 32'h0000_ABCD, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h0000_ABCD, 1'b1, 1'b1);
        #1;
        checkOutput("flush_run_ready", 64'(in_ready), 64'd0);
        tick();
        checkToken("flush_run_tok", 1'b1, 32'h0000_ABCD, 8'd1);
        tick();
        checkOutput("flush_run_drained", 64'(out_valid), 64'd0);
        flush = 1'b0;
        #1;
        checkOutput("flush_drop_ready", 64'(in_ready), 64'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        checkToken("flush_late_word", 1'b1, 32'h0000_ABCD, 8'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        tick();

        // ---------------- reset mid-run ----------------
        applyStimulus(1'b1, 32'h1111_0000, 1'b0, 1'b1);
        tick();
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 64'(out_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        checkOutput("midrst_flush_no_token", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, 32'h1111_0000, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        checkToken("midrst_fresh_run", 1'b1, 32'h1111_0000, 8'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput("final_drained", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rle_xor_encoder.md
# rle_xor_encoder

Streaming run-length encoder front end for the RLE ASIC. It accepts 32-bit words over a valid/ready handshake and compares each word with the held word using the existing 32-bit `xor_gate` datapath; a zero XOR result extends the current run. It emits (word, run length) tokens over a second valid/ready handshake, and it sequences the XOR comparator so that exactly one comparison happens per accepted word.

## Interface
- `CNT_W`, default 8: run-counter width. Maximum run length is MAX = 2^CNT_W − 1.
- Data width is fixed at 32 to match `xor_gate`. It is not a parameter.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  encoder accepts the word (combinational).
- `in_data`  in  32  input word.
- `flush`  in  1  close the current run and emit it; level-sensitive.
- `out_valid`  out  1  token valid (registered).
- `out_ready`  in  1  downstream accepts the token.
- `out_data`  out  32  run word.
- `out_count`  out  CNT_W  run length, 1..MAX.

## Operation
- **State:**
  - FSM state: IDLE or RUN.
  - `hold` (32) and `count` (CNT_W) registers.
  - One output slot (`out_valid` / `out_data` / `out_count`).
- `slot_free` = !out_valid || out_ready.
- `in_ready` = !flush && slot_free.
- An input is accepted when `in_valid && in_ready`.
- `diff` = `hold ^ in_data` via `xor_gate`. Match = (`diff` == 0).
- **IDLE, word accepted:**
  - `hold` ← `in_data`, `count` ← 1.
  - Go to RUN.
- **RUN, word accepted:**
  - Match && `count` < MAX: `count` ← `count` + 1.
  - Mismatch, or `count` == MAX: load slot with (`hold`, `count`) and set `out_valid`. Then `hold` ← `in_data`, `count` ← 1. Stay in RUN.
- **RUN, `flush` && `slot_free`:**
  - Load slot with (`hold`, `count`) and set `out_valid`.
  - Go to IDLE; `count` ← 0.
- `flush` in IDLE has no effect. `flush` forces `in_ready` low, so a flush and an input never occur in the same cycle.
- **Output slot:**
  - Cleared when `out_ready && out_valid` and no new load occurs in that cycle.
  - On a same-cycle drain and load, the new token replaces the old one with `out_valid` held at 1.
- **Reset values:**
  - State IDLE; `out_valid` 0, `out_data` 0, `out_count` 0.
  - `hold` 0, `count` 0.
  - `in_ready` 1 while `flush` is low.

## Timing
- Token for a run appears on `out_*` in the cycle after the edge where the breaking word or flush is accepted. Latency is 1 cycle.
- Throughput: one input word per cycle while `out_ready` is high.
- While `out_valid && !out_ready`, `out_data` / `out_count` are stable and `in_ready` = 0. This also stalls run-extending words.
- `out_count` never equals 0 while `out_valid` = 1.
- Saturation: the (MAX+1)-th equal word emits (word, MAX) and starts a new run at 1. There is no wrap to 0.
- `rst_n` low mid-run: the run is discarded immediately and asynchronously. Any pending token is dropped (`out_valid` → 0) with no partial emission.

## Structure
- **Shared package `rle_pkg`:**
  - `RLE_DATA_W` = 32.
  - Default `RLE_CNT_W` = 8.
  - State enum `rle_state_t` {IDLE, RUN}.
- **Sub-module:** one `xor_gate` instance (`U_xor_gate`) computes `diff`; zero detect is a reduction NOR in this block.
- Remaining logic is a single FSM plus counter and output register, about 150–200 lines.

## Test plan
- **Reset:** hold `rst_n` low → `out_valid` 0, `out_count` 0, `in_ready` 1. Release; idle 5 cycles → no token.
- **Basic runs:** send `32'h0000_1111` ×3, then `32'h5555_5555` ×1, then pulse `flush` → tokens (`0000_1111`, 3) then (`5555_5555`, 1). Each token is 1 cycle after its break/flush edge.
- **Saturation:** send 300 × `32'hFFFF_FFFF`, then `flush` → tokens (`FFFF_FFFF`, 255), (`FFFF_FFFF`, 45).
- **Backpressure:**
  - Stimulus: `out_ready` = 0; offer A=`0000_0001`, B=`0000_0002`, C=`0000_0003` back-to-back.
  - Required: A and B are accepted; `in_ready` drops after B. Token (A, 1) is held stable.
  - On raising `out_ready`: C is accepted in the same cycle; `flush` yields (B, 1), (C, 1); no word is lost.
- **Flush corner:** `flush` in IDLE → no token. `flush` high with `in_valid` high in RUN → `in_ready` = 0, token emitted, and the word is accepted only after `flush` drops.
- **Reset mid-run:** send `1111_0000` ×2, assert `rst_n` low for 1 cycle, then `flush` → no token. The next word starts a fresh run with count 1.
